// File: rtl/joy_db_pkg.sv
// Shared definitions for the DB15 / DB9-MD joystick link blocks:
// button bit positions, button count and the DB15 responder state encoding.
package joy_db_pkg;

  localparam int JOY_BTNS = 12;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_X = 7;
  localparam int BTN_Y = 8;
  localparam int BTN_Z = 9;
  localparam int BTN_E = 10;
  localparam int BTN_F = 11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } db15_tx_state_t;

endpackage

// File: rtl/joy_sync.sv
// N-stage synchronizer for an asynchronous pin, followed by one extra
// register stage that provides rise/fall detection on the synchronized level.
module joy_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Reset to the pin's idle level so releasing reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick responder: emulates the reader-polled shift-register chains,
// latching both player words on JOY_LOAD and shifting them out LSB first.
import joy_db_pkg::*;

module joy_db15_tx #(
  parameter int NBITS       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic        frame_done,
  output logic [4:0]  bit_count
);

  // With NBITS = 32 the 5-bit count wraps to 0 on the final shift; frame_done
  // and the DONE state still mark the end of the frame.
  localparam logic [4:0] LAST_IDX = 5'(NBITS - 1);

  logic clk_level_unused, clk_fall_unused, clk_rise;
  logic load_level, load_rise_unused, load_fall_unused;

  joy_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (joy_clk),
    .level   (clk_level_unused),
    .rise    (clk_rise),
    .fall    (clk_fall_unused)
  );

  joy_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_load_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (joy_load),
    .level   (load_level),
    .rise    (load_rise_unused),
    .fall    (load_fall_unused)
  );

  db15_tx_state_t   state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [4:0]       count_q, count_d;
  logic             frame_done_q, frame_done_d;
  logic [31:0]      frame_ext;
  logic [NBITS-1:0] frame;

  // Buttons are active high, the serial line is active low; bits past the
  // two player words read as released.
  always_comb begin
    frame_ext = {8'hFF, ~joystick2, ~joystick1};
    frame     = frame_ext[NBITS-1:0];
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    frame_done_d = 1'b0;

    if (!load_level) begin
      state_d = LOAD;
      shreg_d = frame;
      count_d = 5'd0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        LOAD: state_d = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            shreg_d = {1'b1, shreg_q[NBITS-1:1]};
            count_d = count_q + 5'd1;
            if (count_q == LAST_IDX) begin
              frame_done_d = 1'b1;
              state_d      = DONE;
            end
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shreg_q      <= '1;
      count_q      <= 5'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign joy_data   = shreg_q[0];
  assign frame_done = frame_done_q;
  assign bit_count  = count_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: acts as the polling reader and scores each
// serial bit against a queue of expected bits built from the loaded words.
module tb_joy_db15_tx;

  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] joystick1, joystick2;
  logic        joy_clk, joy_load;
  logic        joy_data, frame_done;
  logic [4:0]  bit_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int done_cnt = 0;
  int done_base;
  bit exp_q[$];

  joy_db15_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected serial stream: inverted P1 word then inverted P2 word, LSB first,
  // followed by fill ones for any overrun clocks.
  task automatic pushFrame(input logic [11:0] j1, input logic [11:0] j2, input int extra);
    logic [23:0] w;
    w = {~j2, ~j1};
    for (int i = 0; i < 24; i++) exp_q.push_back(w[i]);
    for (int i = 0; i < extra; i++) exp_q.push_back(1'b1);
  endtask

  task automatic applyStimulus(input logic [11:0] j1, input logic [11:0] j2, input int extra);
    @(negedge clk);
    joystick1 = j1;
    joystick2 = j2;
    joy_load  = 1'b0;
    waitCycles(HALF);
    pushFrame(j1, j2, extra);
    joy_load = 1'b1;
    waitCycles(HALF);
  endtask

  task automatic shiftBits(input int n, input string tag);
    bit e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $error("[TB] FAIL %s_queue: observed empty scoreboard expected a pending bit", tag);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("%s_bit%0d", tag, k), {31'd0, joy_data}, {31'd0, e});
      end
      joy_clk = 1'b1;
      waitCycles(HALF);
      joy_clk = 1'b0;
      waitCycles(HALF);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    joy_load  = 1'b0;
    joy_clk   = 1'b0;
    joystick1 = 12'h005;
    joystick2 = 12'h800;
    waitCycles(5);
    checkOutput("reset_data", {31'd0, joy_data}, 32'd1);
    checkOutput("reset_count", {27'd0, bit_count}, 32'd0);
    checkOutput("reset_done", {31'd0, frame_done}, 32'd0);
    reset_n = 1'b1;
    waitCycles(HALF);

    $display("[TB] full frame");
    done_base = done_cnt;
    applyStimulus(12'h005, 12'h800, 0);
    checkOutput("full_load_count", {27'd0, bit_count}, 32'd0);
    shiftBits(24, "full");
    checkOutput("full_count", {27'd0, bit_count}, 32'd24);
    checkOutput("full_done_pulses", done_cnt - done_base, 32'd1);
    checkOutput("full_data_after", {31'd0, joy_data}, 32'd1);

    $display("[TB] overrun");
    done_base = done_cnt;
    applyStimulus(12'h005, 12'h800, 6);
    shiftBits(30, "over");
    checkOutput("over_count", {27'd0, bit_count}, 32'd24);
    checkOutput("over_done_pulses", done_cnt - done_base, 32'd1);

    $display("[TB] input change mid-frame");
    done_base = done_cnt;
    applyStimulus(12'h0A5, 12'h3C3, 0);
    shiftBits(5, "mid_a");
    joystick1 = 12'hFFF;
    shiftBits(19, "mid_b");
    checkOutput("mid_done_pulses", done_cnt - done_base, 32'd1);
    applyStimulus(12'hFFF, 12'h3C3, 0);
    checkOutput("mid_reload_count", {27'd0, bit_count}, 32'd0);
    shiftBits(24, "mid_c");

    $display("[TB] simultaneous edges");
    applyStimulus(12'h3F0, 12'h000, 0);
    shiftBits(3, "sim_pre");
    exp_q.delete();
    @(negedge clk);
    joystick1 = 12'h001;
    joy_load  = 1'b0;
    joy_clk   = 1'b1;
    waitCycles(HALF);
    checkOutput("sim_fall_count", {27'd0, bit_count}, 32'd0);
    checkOutput("sim_fall_data", {31'd0, joy_data}, 32'd0);
    joy_clk = 1'b0;
    waitCycles(HALF);
    joy_load = 1'b1;
    joy_clk  = 1'b1;
    waitCycles(HALF);
    checkOutput("sim_rise_count", {27'd0, bit_count}, 32'd0);
    checkOutput("sim_rise_data", {31'd0, joy_data}, 32'd0);
    joy_clk = 1'b0;
    waitCycles(HALF);
    done_base = done_cnt;
    pushFrame(12'h001, 12'h000, 0);
    shiftBits(24, "sim_frame");
    checkOutput("sim_done_pulses", done_cnt - done_base, 32'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(12'h5A5, 12'h0F0, 0);
    shiftBits(10, "rst_pre");
    done_base = done_cnt;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_data", {31'd0, joy_data}, 32'd1);
    checkOutput("rst_count", {27'd0, bit_count}, 32'd0);
    checkOutput("rst_done", {31'd0, frame_done}, 32'd0);
    waitCycles(4);
    reset_n = 1'b1;
    waitCycles(HALF);
    checkOutput("rst_idle_data", {31'd0, joy_data}, 32'd1);
    checkOutput("rst_no_pulse", done_cnt - done_base, 32'd0);
    exp_q.delete();
    done_base = done_cnt;
    applyStimulus(12'h005, 12'h800, 0);
    shiftBits(24, "rst_clean");
    checkOutput("rst_clean_count", {27'd0, bit_count}, 32'd24);
    checkOutput("rst_clean_pulses", done_cnt - done_base, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
